puf_eval_ctrl: RTL and testbench
================================

// Module: puf_eval_ctrl
// PURPOSE
//  Wishbone-slave controller that sequences one PUF evaluation: drives the challenge,
//  pulses launch, waits a programmable settle time, then captures the response.
//  Sits in the user project between the management SoC Wishbone bus and the PUF core.
//  Raises a maskable completion interrupt.
// PARAMETERS
//  BASE_ADDR       32'h3000_0000  register block base; decode uses wbs_adr_i[31:5]
//  RESP_W          32             PUF response width (1..32); challenge is fixed at 32b
//  SETTLE_DEFAULT  8              reset value of SETTLE register (cycles)
//  NUM_EVAL        7              evaluations per run when voting is enabled; odd, 3..15
// PORTS
//  wb_clk_i         in   1       single clock for all logic
//  wb_rst_i         in   1       synchronous, active-high reset
//  wbs_stb_i        in   1       Wishbone strobe
//  wbs_cyc_i        in   1       Wishbone cycle
//  wbs_we_i         in   1       1=write
//  wbs_sel_i        in   4       byte enables (honoured on CHALLENGE/SETTLE)
//  wbs_adr_i        in   32      byte address
//  wbs_dat_i        in   32      write data
//  wbs_ack_o        out  1       single-cycle acknowledge
//  wbs_dat_o        out  32      read data
//  puf_challenge_o  out  32      challenge to PUF core
//  puf_launch_o     out  1       one-cycle launch pulse to PUF core
//  puf_response_i   in   RESP_W  PUF response, valid after settle
//  irq_o            out  1       level interrupt = DONE & IRQ_EN
// BEHAVIOUR
//  Regs (offset): 0x00 CTRL W: b0 START(w1), b1 IRQ_EN(rw), b2 CLR_DONE(w1); 0x04 STATUS RO:
//   b0 BUSY, b1 DONE; 0x08 CHALLENGE rw; 0x0C SETTLE rw[7:0]; 0x10 RESPONSE RO, zero-extended.
//  Unmapped offsets: writes dropped, reads 0x0. Reads of CTRL return {30'b0,IRQ_EN,1'b0}.
//  Ack: registered; asserted the cycle after stb&cyc&~ack, so max 1 access per 2 cycles.
//  Reset: ack=0, dat_o=0, challenge=0, launch=0, irq=0, SETTLE=SETTLE_DEFAULT,
//   RESPONSE=0, IRQ_EN=0, DONE=0, FSM=IDLE, all counters 0.
//  FSM: IDLE -START-> LAUNCH (launch_o=1, 1 cycle) -> SETTLE (count SETTLE cycles;
//   SETTLE=0 treated as 1) -> SAMPLE (capture puf_response_i) -> LAUNCH if evals
//   remain, else DONE_ST (write RESPONSE, set DONE, 1 cycle) -> IDLE.
//  START takes effect on the ack cycle; single eval: RESPONSE valid, DONE=1 at
//   ack+SETTLE+3 cycles. BUSY=1 in every state except IDLE.
//  START while BUSY: ignored. CHALLENGE/SETTLE writes while BUSY: ignored (acked).
//  START clears DONE; START+CLR_DONE same write: START wins, DONE=0.
//  CLR_DONE while DONE sets in the same cycle: set wins.
//  challenge_o is held stable from LAUNCH through SAMPLE of every evaluation.
//  Reset mid-run: FSM to IDLE next edge, launch_o=0, RESPONSE cleared, no irq.
// CONFIGURATION
//  PUF_MAJORITY_VOTE_EN defined: run = NUM_EVAL evaluations; per-bit counters
//   ($clog2(NUM_EVAL+1) bits) incremented in SAMPLE; RESPONSE bit = count > NUM_EVAL/2;
//   counters cleared on START. Latency = NUM_EVAL*(SETTLE+2)+1 cycles after ack.
//  Undefined: exactly one evaluation; RESPONSE = raw sample; no counters synthesized.
// TESTING
//  Reset, read all regs -> SETTLE=8, others 0; irq_o=0, launch_o never pulsed.
//  CHALLENGE=0xA5A5_5A5A, SETTLE=4, START; PUF model returns 0x1234_5678 -> one
//   launch pulse, DONE at ack+7, RESPONSE=0x1234_5678, challenge_o stable throughout.
//  IRQ_EN=1, run to DONE -> irq_o=1; write CLR_DONE -> irq_o=0 next cycle, STATUS=0.
//  START + CHALLENGE write during BUSY -> no extra launch, CHALLENGE unchanged.
//  Vote build, NUM_EVAL=7, model returns 0xFF on 4 evals and 0x0F on 3 -> 7 launch
//   pulses, RESPONSE=0xFF; with 3x 0xFF / 4x 0x0F -> RESPONSE=0x0F.
//  Assert wb_rst_i during SETTLE -> IDLE next cycle, BUSY=0, RESPONSE=0, irq_o=0.

Source files
------------

// File: rtl/puf_eval_ctrl.sv
// rtl/puf_eval_ctrl.sv - Wishbone-controlled PUF evaluation sequencer with settle timer and completion irq
// Optional majority voting over NUM_EVAL evaluations: define PUF_MAJORITY_VOTE_EN.
module puf_eval_ctrl #(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int          RESP_W         = 32,
    parameter int          SETTLE_DEFAULT = 8,
    parameter int          NUM_EVAL       = 7
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic [31:0]       puf_challenge_o,
    output logic              puf_launch_o,
    input  logic [RESP_W-1:0] puf_response_i,
    output logic              irq_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_ack;
    logic [31:0]         r_dat;
    logic [31:0]         r_challenge;
    logic [7:0]          r_settle;
    logic [7:0]          r_settle_cnt;
    logic [RESP_W-1:0]   r_response;
    logic                r_irq_en;
    logic                r_done;

    logic                w_busy;
    logic                w_launch;
    logic                w_hit;
    logic [2:0]          w_off;
    logic                w_req;
    logic                w_wr;
    logic                w_start;
    logic                w_clr;
    logic                w_cfg_ok;
    logic [7:0]          w_settle_eff;
    logic                w_settle_end;
    logic                w_last_eval;
    logic [RESP_W-1:0]   w_result;
    logic [31:0]         w_resp_ext;
    logic [31:0]         w_rd_data;
    logic                w_unused;

    assign w_hit    = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign w_off    = wbs_adr_i[4:2];
    assign w_req    = wbs_stb_i & wbs_cyc_i & ~r_ack;
    assign w_wr     = w_req & wbs_we_i & w_hit;
    assign w_start  = w_wr && (w_off == 3'd0) && wbs_dat_i[0] && (r_state == S_IDLE);
    assign w_clr    = w_wr && (w_off == 3'd0) && wbs_dat_i[2];
    assign w_cfg_ok = w_wr && (r_state == S_IDLE);
    assign w_unused = ^wbs_adr_i[1:0];

    // A zero settle still spends one cycle so the PUF output has a chance to resolve.
    assign w_settle_eff = (r_settle == 8'd0) ? 8'd1 : r_settle;
    assign w_settle_end = (r_settle_cnt == (w_settle_eff - 8'd1));

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int CW = $clog2(NUM_EVAL + 1);
    localparam logic [CW-1:0] HALF = CW'(NUM_EVAL / 2);

    logic [CW-1:0] r_eval_cnt;
    logic [CW-1:0] r_votes [RESP_W];

    assign w_last_eval = (r_eval_cnt == CW'(NUM_EVAL - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || w_start) begin
            r_eval_cnt <= '0;
            for (int b = 0; b < RESP_W; b++) r_votes[b] <= '0;
        end else if (r_state == S_SAMPLE) begin
            r_eval_cnt <= r_eval_cnt + CW'(1);
            for (int b = 0; b < RESP_W; b++) r_votes[b] <= r_votes[b] + CW'(puf_response_i[b]);
        end
    end

    always_comb begin
        w_result = '0;
        for (int b = 0; b < RESP_W; b++) w_result[b] = (r_votes[b] > HALF);
    end
`else
    logic [RESP_W-1:0] r_sample;

    assign w_last_eval = 1'b1;
    assign w_result    = r_sample;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)                 r_sample <= '0;
        else if (r_state == S_SAMPLE) r_sample <= puf_response_i;
    end
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_SETTLE;
            S_SETTLE: if (w_settle_end) w_next = S_SAMPLE;
            S_SAMPLE: w_next = w_last_eval ? S_DONE : S_LAUNCH;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (r_state != S_IDLE);
        w_launch = (r_state == S_LAUNCH);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || r_state != S_SETTLE) r_settle_cnt <= 8'd0;
        else                                 r_settle_cnt <= r_settle_cnt + 8'd1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_challenge <= 32'd0;
            r_settle    <= 8'(SETTLE_DEFAULT);
            r_irq_en    <= 1'b0;
        end else if (w_wr) begin
            if (w_off == 3'd0) r_irq_en <= wbs_dat_i[1];
            if (w_cfg_ok && w_off == 3'd2) begin
                for (int i = 0; i < 4; i++)
                    if (wbs_sel_i[i]) r_challenge[8*i +: 8] <= wbs_dat_i[8*i +: 8];
            end
            if (w_cfg_ok && w_off == 3'd3 && wbs_sel_i[0]) r_settle <= wbs_dat_i[7:0];
        end
    end

    // Completion set outranks any clear; START only lands in IDLE so it never meets a set.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_done     <= 1'b0;
            r_response <= '0;
        end else if (r_state == S_DONE) begin
            r_done     <= 1'b1;
            r_response <= w_result;
        end else if (w_start || w_clr) begin
            r_done     <= 1'b0;
        end
    end

    always_comb begin
        w_resp_ext = 32'd0;
        w_resp_ext[RESP_W-1:0] = r_response;
        w_rd_data = 32'd0;
        if (w_hit) begin
            case (w_off)
                3'd0:    w_rd_data = {30'd0, r_irq_en, 1'b0};
                3'd1:    w_rd_data = {30'd0, r_done, w_busy};
                3'd2:    w_rd_data = r_challenge;
                3'd3:    w_rd_data = {24'd0, r_settle};
                3'd4:    w_rd_data = w_resp_ext;
                default: w_rd_data = 32'd0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= 32'd0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req && !wbs_we_i) ? w_rd_data : 32'd0;
        end
    end

    assign wbs_ack_o       = r_ack;
    assign wbs_dat_o       = r_dat;
    assign puf_challenge_o = r_challenge;
    assign puf_launch_o    = w_launch;
    assign irq_o           = r_done & r_irq_en;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb/tb_puf_eval_ctrl.sv - directed self-checking bench for puf_eval_ctrl
module tb_puf_eval_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_STAT = BASE + 32'h04;
    localparam logic [31:0] A_CHAL = BASE + 32'h08;
    localparam logic [31:0] A_SETL = BASE + 32'h0C;
    localparam logic [31:0] A_RESP = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'd0;
    logic [31:0] dat_i = 32'd0;
    logic        ack;
    logic [31:0] dat_o;
    logic [31:0] challenge;
    logic        launch;
    logic [31:0] puf_resp = 32'd0;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    int launch_total = 0;
    int model_base = 0;
    logic [31:0] model_vals [16];

    always #5 clk = ~clk;

    puf_eval_ctrl dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o), .puf_challenge_o(challenge),
        .puf_launch_o(launch), .puf_response_i(puf_resp), .irq_o(irq)
    );

    // PUF model: each launch presents the next value from model_vals.
    always @(posedge clk) begin
        if (launch) begin
            puf_resp     <= model_vals[(launch_total - model_base) % 16];
            launch_total <= launch_total + 1;
        end
    end

    task automatic wb_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic w, output logic [31:0] rd);
        int n;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        n = 0;
        rd = 32'd0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 20);
        n_cmp++;
        if (!ack) begin
            n_err++;
            $display("FAIL bus_ack addr=%h: no ack within 20 cycles", a);
        end
        rd = dat_o;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] unused_rd;
        wb_access(a, d, 4'hF, 1'b1, unused_rd);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        wb_access(a, 32'd0, 4'hF, 1'b0, d);
    endtask

    // Counts cycles after the START ack until irq rises; also counts challenge glitches.
    task automatic wait_irq(input logic [31:0] exp_chal, output int cyc_n, output int bad);
        cyc_n = 0;
        bad = 0;
        do begin
            @(posedge clk); #1;
            cyc_n++;
            if (challenge !== exp_chal) bad++;
        end while (!irq && cyc_n < 500);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL rst_ack got=%b exp=0", ack); end
        n_cmp++; if (dat_o !== 32'd0) begin n_err++; $display("FAIL rst_dat got=%h exp=0", dat_o); end
        n_cmp++; if (challenge !== 32'd0) begin n_err++; $display("FAIL rst_chal got=%h exp=0", challenge); end
        n_cmp++; if (launch !== 1'b0 || irq !== 1'b0) begin n_err++; $display("FAIL rst_launch_irq got=%b%b exp=00", launch, irq); end
        @(negedge clk); rst = 1'b0;
        wb_read(A_CTRL, rd);
        n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL rst_ctrl got=%h exp=0", rd); end
        wb_read(A_STAT, rd);
        n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL rst_status got=%h exp=0", rd); end
        wb_read(A_CHAL, rd);
        n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL rst_chal_reg got=%h exp=0", rd); end
        wb_read(A_SETL, rd);
        n_cmp++; if (rd !== 32'd8) begin n_err++; $display("FAIL rst_settle got=%h exp=8", rd); end
        wb_read(A_RESP, rd);
        n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL rst_resp got=%h exp=0", rd); end
        n_cmp++; if (launch_total !== 0) begin n_err++; $display("FAIL rst_no_launch got=%0d exp=0", launch_total); end
    endtask

    task automatic test_single();
        logic [31:0] rd;
        int k, bad;
        wb_write(A_SETL, 32'd4);
        wb_write(A_CHAL, 32'hA5A5_5A5A);
        model_vals[0] = 32'h1234_5678;
        model_base = launch_total;
        wb_write(A_CTRL, 32'h3);
        wait_irq(32'hA5A5_5A5A, k, bad);
        n_cmp++; if (k !== 7) begin n_err++; $display("FAIL single_latency got=%0d exp=7", k); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL single_chal_stable glitches=%0d exp=0", bad); end
        n_cmp++; if (launch_total - model_base !== 1) begin n_err++; $display("FAIL single_launches got=%0d exp=1", launch_total - model_base); end
        wb_read(A_RESP, rd);
        n_cmp++; if (rd !== 32'h1234_5678) begin n_err++; $display("FAIL single_resp got=%h exp=12345678", rd); end
        wb_read(A_STAT, rd);
        n_cmp++; if (rd !== 32'h2) begin n_err++; $display("FAIL single_status got=%h exp=2", rd); end
    endtask

    task automatic test_irq_clear();
        logic [31:0] rd;
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_high got=%b exp=1", irq); end
        wb_write(A_CTRL, 32'h6);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_cleared got=%b exp=0", irq); end
        wb_read(A_STAT, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL clr_status got=%h exp=0", rd); end
        wb_read(A_CTRL, rd);
        n_cmp++; if (rd !== 32'h2) begin n_err++; $display("FAIL ctrl_readback got=%h exp=2", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int k, bad;
        model_vals[0] = 32'h0BAD_F00D;
        model_base = launch_total;
        wb_write(A_CTRL, 32'h3);
        wb_write(A_CHAL, 32'h1111_1111);
        wb_write(A_CTRL, 32'h3);
        wb_read(A_STAT, rd);
        n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL b2b_busy got=%h exp=1", rd); end
        wait_irq(32'hA5A5_5A5A, k, bad);
        n_cmp++; if (!irq) begin n_err++; $display("FAIL b2b_done irq=%b exp=1", irq); end
        repeat (12) @(posedge clk);
        #1;
        n_cmp++; if (launch_total - model_base !== 1) begin n_err++; $display("FAIL b2b_launches got=%0d exp=1", launch_total - model_base); end
        wb_read(A_CHAL, rd);
        n_cmp++; if (rd !== 32'hA5A5_5A5A) begin n_err++; $display("FAIL b2b_chal got=%h exp=a5a55a5a", rd); end
        wb_read(A_RESP, rd);
        n_cmp++; if (rd !== 32'h0BAD_F00D) begin n_err++; $display("FAIL b2b_resp got=%h exp=0badf00d", rd); end
    endtask

    task automatic test_settle_zero();
        logic [31:0] rd;
        int k, bad;
        wb_write(A_SETL, 32'd0);
        model_vals[0] = 32'hCAFE_0001;
        model_base = launch_total;
        wb_write(A_CTRL, 32'h3);
        wait_irq(32'hA5A5_5A5A, k, bad);
        n_cmp++; if (k !== 4) begin n_err++; $display("FAIL settle0_latency got=%0d exp=4", k); end
        wb_read(A_RESP, rd);
        n_cmp++; if (rd !== 32'hCAFE_0001) begin n_err++; $display("FAIL settle0_resp got=%h exp=cafe0001", rd); end
    endtask

    task automatic test_decode_sel();
        logic [31:0] rd;
        wb_access(A_CHAL, 32'hFFFF_FFFF, 4'b0011, 1'b1, rd);
        wb_read(A_CHAL, rd);
        n_cmp++; if (rd !== 32'hA5A5_FFFF) begin n_err++; $display("FAIL sel_chal got=%h exp=a5a5ffff", rd); end
        wb_write(32'h4000_0008, 32'h0);
        wb_read(A_CHAL, rd);
        n_cmp++; if (rd !== 32'hA5A5_FFFF) begin n_err++; $display("FAIL foreign_base got=%h exp=a5a5ffff", rd); end
        wb_read(BASE + 32'h14, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL unmapped_read got=%h exp=0", rd); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] rd;
        wb_write(A_SETL, 32'd8);
        model_base = launch_total;
        wb_write(A_CTRL, 32'h3);
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (launch !== 1'b0 || irq !== 1'b0) begin n_err++; $display("FAIL midrst_outputs got=%b%b exp=00", launch, irq); end
        @(negedge clk); rst = 1'b0;
        wb_read(A_STAT, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL midrst_status got=%h exp=0", rd); end
        wb_read(A_RESP, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL midrst_resp got=%h exp=0", rd); end
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (launch_total - model_base !== 1 || irq !== 1'b0) begin n_err++; $display("FAIL midrst_quiet launches=%0d irq=%b exp=1,0", launch_total - model_base, irq); end
    endtask

`ifdef PUF_MAJORITY_VOTE_EN
    task automatic test_vote(input logic [31:0] first, input logic [31:0] second, input logic [31:0] exp);
        logic [31:0] rd;
        int k, bad;
        for (int i = 0; i < 7; i++) model_vals[i] = (i % 2 == 0) ? first : second;
        wb_write(A_SETL, 32'd4);
        model_base = launch_total;
        wb_write(A_CTRL, 32'h3);
        wait_irq(challenge, k, bad);
        n_cmp++; if (k !== 43) begin n_err++; $display("FAIL vote_latency got=%0d exp=43", k); end
        n_cmp++; if (launch_total - model_base !== 7) begin n_err++; $display("FAIL vote_launches got=%0d exp=7", launch_total - model_base); end
        wb_read(A_RESP, rd);
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL vote_resp got=%h exp=%h", rd, exp); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) model_vals[i] = 32'd0;
        test_reset();
        test_single();
        test_irq_clear();
        test_back_to_back();
        test_settle_zero();
        test_decode_sel();
        test_reset_mid_run();
`ifdef PUF_MAJORITY_VOTE_EN
        test_vote(32'hFF, 32'h0F, 32'hFF);
        test_vote(32'h0F, 32'hFF, 32'h0F);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
